// File: rtl/pickup_code_ctrl_pkg.sv
// Shared types and constants for the express-box pickup-code controller.
package express_box_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_OPEN,
    S_ERROR,
    S_LOCKOUT,
    S_SETCODE
  } state_e;

  localparam logic [3:0] KEY_CLR = 4'hA;
  localparam logic [3:0] KEY_BS  = 4'hB;
  localparam logic [3:0] KEY_ENT = 4'hC;
  localparam logic [3:0] KEY_SET = 4'hD;

  localparam logic [3:0] STAT_IDLE  = 4'h0;
  localparam logic [3:0] STAT_ENTRY = 4'h1;
  localparam logic [3:0] STAT_OPEN  = 4'h2;
  localparam logic [3:0] STAT_SET   = 4'h5;
  localparam logic [3:0] STAT_ERR   = 4'hE;
  localparam logic [3:0] STAT_LOCK  = 4'hF;

  function automatic logic [3:0] status_digit(input state_e s);
    case (s)
      S_IDLE:            return STAT_IDLE;
      S_ENTRY, S_CHECK:  return STAT_ENTRY;
      S_OPEN:            return STAT_OPEN;
      S_SETCODE:         return STAT_SET;
      S_ERROR:           return STAT_ERR;
      S_LOCKOUT:         return STAT_LOCK;
      default:           return STAT_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/pickup_code_ctrl_if.sv
// Keypad input and display/actuator outputs of the pickup-code controller.
interface pickup_code_ctrl_if;
  logic       key_strobe;
  logic [3:0] key_code;
  logic [3:0] hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic [7:0] en;
  logic       door_open;
  logic       alarm;

  modport master (
    output key_strobe, key_code,
    input  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7, en, door_open, alarm
  );

  modport slave (
    input  key_strobe, key_code,
    output hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7, en, door_open, alarm
  );
endinterface

// File: rtl/pickup_code_ctrl_hold_timer.sv
// Loadable 32-bit down-counter; done is high while the count reads 1.
module hold_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        done
);

  logic [31:0] cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 32'd1;
    end
  end

  assign done = (cnt_q == 32'd1);

endmodule

// File: rtl/pickup_code_ctrl.sv
// Pickup-code FSM: digit entry, code check, door release, lockout and code change.
module pickup_code_ctrl
  import express_box_pkg::*;
#(
  parameter logic [15:0] DEFAULT_CODE = 16'h1234,
  parameter int unsigned MAX_TRIES    = 3,
  parameter logic [31:0] OPEN_CYCLES  = 32'd5_000_000,
  parameter logic [31:0] ERR_CYCLES   = 32'd1_000_000,
  parameter logic [31:0] LOCK_CYCLES  = 32'd50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  pickup_code_ctrl_if.slave bus
);

  state_e          state_q, nxt_state;
  logic [2:0]      count_q, nxt_count;
  logic [3:0][3:0] dig_q, nxt_dig;
  logic [3:0]      fail_q, nxt_fail;
  logic [15:0]     code_q, nxt_code;
  logic [7:0][3:0] hex_q;
  logic [7:0]      en_q;
  logic            door_open_q, alarm_q;

  logic            is_digit, is_clr, is_bs, is_ent, is_set;
  logic [1:0]      bs_idx;
  logic            timer_load, timer_done;
  logic [31:0]     timer_val;

  assign is_digit = bus.key_strobe && (bus.key_code <= 4'd9);
  assign is_clr   = bus.key_strobe && (bus.key_code == KEY_CLR);
  assign is_bs    = bus.key_strobe && (bus.key_code == KEY_BS);
  assign is_ent   = bus.key_strobe && (bus.key_code == KEY_ENT);
  assign is_set   = bus.key_strobe && (bus.key_code == KEY_SET);
  assign bs_idx   = 2'(count_q - 3'd1);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    nxt_state = state_q;
    nxt_count = count_q;
    nxt_dig   = dig_q;
    nxt_fail  = fail_q;
    nxt_code  = code_q;

    case (state_q)
      S_IDLE: begin
        if (is_digit) begin
          nxt_state  = S_ENTRY;
          nxt_dig[0] = bus.key_code;
          nxt_count  = 3'd1;
        end
      end
      S_ENTRY, S_SETCODE: begin
        if (is_digit) begin
          if (count_q < 3'd4) begin
            nxt_dig[count_q[1:0]] = bus.key_code;
            nxt_count             = count_q + 3'd1;
          end
        end else if (is_bs) begin
          if (count_q != 3'd0) begin
            // Removed slots are zeroed so unused display digits read 0.
            nxt_dig[bs_idx] = 4'd0;
            nxt_count       = count_q - 3'd1;
            if (state_q == S_ENTRY && count_q == 3'd1) nxt_state = S_IDLE;
          end
        end else if (is_clr) begin
          nxt_count = 3'd0;
          nxt_dig   = '0;
          if (state_q == S_ENTRY) nxt_state = S_IDLE;
        end else if (is_ent && count_q == 3'd4) begin
          if (state_q == S_ENTRY) begin
            nxt_state = S_CHECK;
          end else begin
            nxt_code  = {dig_q[0], dig_q[1], dig_q[2], dig_q[3]};
            nxt_state = S_IDLE;
          end
        end
      end
      S_CHECK: begin
        if (code_q == {dig_q[0], dig_q[1], dig_q[2], dig_q[3]}) begin
          nxt_state = S_OPEN;
          nxt_fail  = 4'd0;
        end else begin
          nxt_fail  = fail_q + 4'd1;
          nxt_state = (nxt_fail == 4'(MAX_TRIES)) ? S_LOCKOUT : S_ERROR;
        end
      end
      S_OPEN: begin
        if (timer_done || is_clr) begin
          nxt_state = S_IDLE;
        end else if (is_set) begin
          nxt_state = S_SETCODE;
          nxt_count = 3'd0;
          nxt_dig   = '0;
        end
      end
      S_ERROR: begin
        if (timer_done) nxt_state = S_IDLE;
      end
      S_LOCKOUT: begin
        if (timer_done) begin
          nxt_state = S_IDLE;
          nxt_fail  = 4'd0;
        end
      end
      default: nxt_state = S_IDLE;
    endcase

    if (nxt_state != state_q &&
        nxt_state inside {S_IDLE, S_ERROR, S_LOCKOUT, S_OPEN}) begin
      nxt_count = 3'd0;
      nxt_dig   = '0;
    end
  end

  // The shared timer is armed on the same edge the FSM enters a timed state.
  always_comb begin
    case (nxt_state)
      S_ERROR:   timer_val = ERR_CYCLES;
      S_LOCKOUT: timer_val = LOCK_CYCLES;
      default:   timer_val = OPEN_CYCLES;
    endcase
    timer_load = (nxt_state != state_q) &&
                 (nxt_state inside {S_OPEN, S_ERROR, S_LOCKOUT});
  end

  hold_timer u_hold_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= 3'd0;
      dig_q       <= '0;
      fail_q      <= 4'd0;
      code_q      <= DEFAULT_CODE;
      hex_q       <= '0;
      en_q        <= 8'b0000_1001;
      door_open_q <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= nxt_state;
      count_q     <= nxt_count;
      dig_q       <= nxt_dig;
      fail_q      <= nxt_fail;
      code_q      <= nxt_code;
      // Outputs are registered from next-state values so they track the FSM
      // on the same edge.
      hex_q[0]    <= status_digit(nxt_state);
      hex_q[1]    <= 4'd0;
      hex_q[2]    <= 4'd0;
      hex_q[3]    <= nxt_fail;
      hex_q[4]    <= nxt_dig[0];
      hex_q[5]    <= nxt_dig[1];
      hex_q[6]    <= nxt_dig[2];
      hex_q[7]    <= nxt_dig[3];
      en_q        <= {nxt_count > 3'd0, nxt_count > 3'd1,
                      nxt_count > 3'd2, nxt_count > 3'd3, 4'b1001};
      door_open_q <= (nxt_state == S_OPEN);
      alarm_q     <= (nxt_state == S_LOCKOUT);
    end
  end

  assign bus.hex0      = hex_q[0];
  assign bus.hex1      = hex_q[1];
  assign bus.hex2      = hex_q[2];
  assign bus.hex3      = hex_q[3];
  assign bus.hex4      = hex_q[4];
  assign bus.hex5      = hex_q[5];
  assign bus.hex6      = hex_q[6];
  assign bus.hex7      = hex_q[7];
  assign bus.en        = en_q;
  assign bus.door_open = door_open_q;
  assign bus.alarm     = alarm_q;

endmodule

// File: tb/tb_pickup_code_ctrl.sv
// Self-checking bench: keypad scenarios against a queue-based reference model.
module tb_pickup_code_ctrl;
  import express_box_pkg::*;

  localparam int OPEN_N = 8;
  localparam int ERR_N  = 4;
  localparam int LOCK_N = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  pickup_code_ctrl_if bus ();

  pickup_code_ctrl #(
    .DEFAULT_CODE (16'h1234),
    .MAX_TRIES    (3),
    .OPEN_CYCLES  (32'(OPEN_N)),
    .ERR_CYCLES   (32'(ERR_N)),
    .LOCK_CYCLES  (32'(LOCK_N))
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_ENTRY, M_CHECK, M_OPEN, M_ERROR, M_LOCK, M_SET} mode_t;
  mode_t mode = M_IDLE;
  int    q[$];
  int    code_d[4] = '{1, 2, 3, 4};
  int    fail = 0;
  int    left = 0;

  task automatic model_step(input logic stb, input logic [3:0] k);
    bit dig, match;
    dig = stb && (k <= 4'd9);
    case (mode)
      M_IDLE: if (dig) begin q.delete(); q.push_back(int'(k)); mode = M_ENTRY; end
      M_ENTRY, M_SET: if (stb) begin
        if (dig) begin
          if (q.size() < 4) q.push_back(int'(k));
        end else if (k == KEY_BS) begin
          if (q.size() > 0) void'(q.pop_back());
          if (mode == M_ENTRY && q.size() == 0) mode = M_IDLE;
        end else if (k == KEY_CLR) begin
          q.delete();
          if (mode == M_ENTRY) mode = M_IDLE;
        end else if (k == KEY_ENT && q.size() == 4) begin
          if (mode == M_ENTRY) mode = M_CHECK;
          else begin
            foreach (code_d[i]) code_d[i] = q[i];
            q.delete();
            mode = M_IDLE;
          end
        end
      end
      M_CHECK: begin
        match = 1'b1;
        foreach (code_d[i]) if (q[i] != code_d[i]) match = 1'b0;
        q.delete();
        if (match) begin mode = M_OPEN; left = OPEN_N; fail = 0; end
        else begin
          fail++;
          if (fail == 3) begin mode = M_LOCK; left = LOCK_N; end
          else begin mode = M_ERROR; left = ERR_N; end
        end
      end
      M_OPEN: begin
        if (left == 1) mode = M_IDLE;
        else begin
          left--;
          if (stb && k == KEY_CLR) mode = M_IDLE;
          else if (stb && k == KEY_SET) mode = M_SET;
        end
      end
      M_ERROR: if (left == 1) mode = M_IDLE; else left--;
      M_LOCK:  if (left == 1) begin mode = M_IDLE; fail = 0; end else left--;
      default: mode = M_IDLE;
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mode = M_IDLE; q.delete(); fail = 0; left = 0; code_d = '{1, 2, 3, 4};
      end else begin
        model_step(bus.key_strobe, bus.key_code);
      end
    end
  end

  function automatic logic [3:0] exp_status();
    case (mode)
      M_IDLE:           return 4'h0;
      M_ENTRY, M_CHECK: return 4'h1;
      M_OPEN:           return 4'h2;
      M_SET:            return 4'h5;
      M_ERROR:          return 4'hE;
      default:          return 4'hF;
    endcase
  endfunction

  function automatic logic [3:0] exp_dig(input int i);
    return (i < q.size()) ? 4'(q[i]) : 4'h0;
  endfunction

  function automatic logic [7:0] exp_en();
    logic [7:0] e;
    e = 8'h09;
    for (int i = 0; i < 4; i++) if (i < q.size()) e[7-i] = 1'b1;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("m_hex0", bus.hex0, exp_status());
    check("m_hex1", bus.hex1, 0);
    check("m_hex2", bus.hex2, 0);
    check("m_hex3", bus.hex3, fail);
    check("m_hex4", bus.hex4, exp_dig(0));
    check("m_hex5", bus.hex5, exp_dig(1));
    check("m_hex6", bus.hex6, exp_dig(2));
    check("m_hex7", bus.hex7, exp_dig(3));
    check("m_en", bus.en, exp_en());
    check("m_door", bus.door_open, mode == M_OPEN);
    check("m_alarm", bus.alarm, mode == M_LOCK);
  end

  // ---------------- directed stimulus ----------------
  task automatic press(input logic [3:0] k);
    bus.key_strobe = 1'b1;
    bus.key_code   = k;
    @(negedge clk);
    bus.key_strobe = 1'b0;
    bus.key_code   = 4'h0;
  endtask

  task automatic enter_code(input logic [15:0] c);
    press(c[15:12]); press(c[11:8]); press(c[7:4]); press(c[3:0]);
  endtask

  // Counts consecutive cycles a condition holds: 0 door, 1 alarm, 2 error digit.
  task automatic count_high(input int sel, output int n);
    n = 0;
    while (n < 200 && ((sel == 0 && bus.door_open) || (sel == 1 && bus.alarm) ||
                       (sel == 2 && bus.hex0 == 4'hE))) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.key_strobe = 1'b0;
    bus.key_code   = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_hex0", bus.hex0, 0);
    check("rst_en", bus.en, 8'b0000_1001);
    check("rst_door", bus.door_open, 0);
    check("rst_alarm", bus.alarm, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Non-digit keys in IDLE do nothing.
    press(4'hE); press(KEY_ENT); press(KEY_SET); press(KEY_BS);
    check("idle_stays", bus.hex0, 0);

    // Correct code.
    enter_code(16'h1234);
    check("entry_en", bus.en, 8'hF9);
    check("entry_hex4", bus.hex4, 1);
    check("entry_hex7", bus.hex7, 4);
    press(KEY_ENT);
    check("check_door_low", bus.door_open, 0);
    check("check_hex0", bus.hex0, 1);
    @(negedge clk);
    check("open_hex0", bus.hex0, 2);
    count_high(0, n);
    check("open_len", n, OPEN_N);

    // Three mismatches.
    for (int t = 1; t <= 3; t++) begin
      enter_code(16'h0000);
      press(KEY_ENT);
      @(negedge clk);
      if (t < 3) begin
        check("err_hex0", bus.hex0, 4'hE);
        check("err_fail", bus.hex3, t);
        count_high(2, n);
        check("err_len", n, ERR_N);
      end else begin
        check("lock_alarm", bus.alarm, 1);
        check("lock_hex0", bus.hex0, 4'hF);
        check("lock_fail", bus.hex3, 3);
        press(4'h5); press(KEY_ENT); press(KEY_SET);
        count_high(1, n);
        check("lock_len", n + 3, LOCK_N);
        check("lock_fail_clr", bus.hex3, 0);
      end
    end

    // Editing.
    press(4'h5); press(4'h6); press(KEY_BS); press(4'h7); press(KEY_CLR);
    press(4'h9); press(KEY_ENT);
    check("edit_en", bus.en, 8'h89);
    check("edit_hex0", bus.hex0, 1);
    check("edit_hex4", bus.hex4, 9);
    press(4'h9); press(4'h8); press(4'h7); press(KEY_ENT);
    @(negedge clk);
    check("edit_err", bus.hex0, 4'hE);
    check("edit_fail", bus.hex3, 1);
    count_high(2, n);

    // Set-code.
    enter_code(16'h1234); press(KEY_ENT); @(negedge clk);
    check("set_open", bus.door_open, 1);
    press(KEY_SET);
    check("set_door_low", bus.door_open, 0);
    check("set_hex0", bus.hex0, 5);
    enter_code(16'h4321); press(KEY_ENT);
    check("set_idle", bus.hex0, 0);
    enter_code(16'h4321); press(KEY_ENT); @(negedge clk);
    check("new_code_open", bus.door_open, 1);
    count_high(0, n);
    check("new_open_len", n, OPEN_N);
    enter_code(16'h1234); press(KEY_ENT); @(negedge clk);
    check("old_code_err", bus.hex0, 4'hE);
    check("old_code_fail", bus.hex3, 1);
    count_high(2, n);

    // Overflow then reset during OPEN.
    enter_code(16'h1234); press(4'h5);
    check("ovf_hex7", bus.hex7, 4);
    check("ovf_en", bus.en, 8'hF9);
    press(KEY_CLR);
    enter_code(16'h4321); press(KEY_ENT); @(negedge clk);
    check("pre_rst_open", bus.door_open, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_door_async", bus.door_open, 0);
    check("rst_en_async", bus.en, 8'b0000_1001);
    check("rst_hex3_async", bus.hex3, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    enter_code(16'h1234); press(KEY_ENT); @(negedge clk);
    check("rst_code_open", bus.door_open, 1);
    count_high(0, n);
    check("rst_open_len", n, OPEN_N);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pickup_code_ctrl.md
# pickup_code_ctrl

Keypad-driven pickup-code controller for the express box. Collects a 4-digit pickup code from debounced key strobes, compares it against a stored code and drives the door-release and alarm outputs. Supports changing the stored code while the door is open. Produces the eight 4-bit digit values and the 8-bit digit-enable mask consumed directly by the seven-segment display driver stage downstream.

## Interface
- `DEFAULT_CODE`, 16'h1234: stored code after reset, 4 BCD digits, first-entered digit in [15:12].
- `MAX_TRIES`, 3: consecutive mismatches that trigger lockout (1..9).
- `OPEN_CYCLES`, 32'd5_000_000: door-open duration in clk cycles.
- `ERR_CYCLES`, 32'd1_000_000: error-display duration.
- `LOCK_CYCLES`, 32'd50_000_000: lockout duration.
- `clk` in 1: system clock; sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_strobe` in 1: one-cycle pulse, key_code valid; already debounced.
- `key_code` in 4: 0-9 digit, A clear, B backspace, C enter, D set-code, E/F ignored.
- `hex0`..`hex7` out 4 each: digit values for display.
- `en` out 8: digit enables. en[7:4] gate hex4..hex7 (en[7]↔hex4); en[3:0] gate hex0..hex3 (en[3]↔hex0).
- `door_open` out 1: high for the whole OPEN state.
- `alarm` out 1: high for the whole LOCKOUT state.

## Operation
- States: IDLE, ENTRY, CHECK, OPEN, ERROR, LOCKOUT, SETCODE.
- IDLE (count=0) → ENTRY on a digit.
- Digit buffer: 4×4 bits; digit i is shown on hex(4+i), and en[7-i] = (i < count).
- In ENTRY and SETCODE:
  - Digit: appended when count<4, ignored at count=4.
  - B: decrements count, ignored at 0; ENTRY returns to IDLE when count reaches 0.
  - A: count←0; ENTRY→IDLE, SETCODE stays.
  - C with count<4: ignored.
  - C with count=4: ENTRY→CHECK.
- In SETCODE, C with count=4 writes the buffer to the stored code, then → IDLE.
- CHECK lasts one cycle, no key accepted. Match → OPEN, fail_cnt←0. Mismatch → fail_cnt+1, then LOCKOUT if the new value = MAX_TRIES, else ERROR.
- OPEN: timer runs OPEN_CYCLES, then → IDLE. A → IDLE immediately. D → SETCODE with count←0 and door_open low. Other keys ignored.
- ERROR: ERR_CYCLES, then → IDLE.
- LOCKOUT: LOCK_CYCLES, then → IDLE with fail_cnt←0.
- All keys are ignored in ERROR and LOCKOUT.
- Every entry into IDLE, ERROR, LOCKOUT or OPEN clears count and the buffer.
- Status display:
  - hex0 = state code: IDLE 0, ENTRY 1, CHECK 1, OPEN 2, SETCODE 5, ERROR E, LOCKOUT F.
  - hex3 = fail_cnt.
  - hex1 = hex2 = 0.
  - en[3:0] = 4'b1001 always.
- Timer: one shared 32-bit down-counter, loaded on state entry. The state exits on the cycle the counter reads 1, so each timed state lasts exactly N cycles.
- E/F keys: no effect in any state.

## Timing
- All outputs are registered and update on the clk edge after the key_strobe cycle.
- Reset values (rst_n low, asynchronous):
  - state IDLE, count 0, fail_cnt 0, stored code DEFAULT_CODE.
  - hex0..hex7 = 0, en = 8'b00001001.
  - door_open 0, alarm 0.
- Enter-to-result latency: C accepted at edge n → CHECK at n+1 → OPEN/ERROR/LOCKOUT visible at n+2.
- key_strobe held high: each high cycle is a separate keypress.
- Reset mid-operation: returns to reset values, including the stored code; door_open drops asynchronously.

## Structure
- Package `express_box_pkg`:
  - state enum;
  - key-code constants (KEY_CLR=A, KEY_BS=B, KEY_ENT=C, KEY_SET=D);
  - status-digit constants.
- Sub-module `hold_timer`: loadable 32-bit down-counter with a `done` pulse, shared by the OPEN, ERROR and LOCKOUT states.
- Everything else stays in one FSM module.

## Test plan
Bench parameters: OPEN_CYCLES=8, ERR_CYCLES=4, LOCK_CYCLES=16.

- Correct code: keys 1,2,3,4,C → door_open rises 2 cycles after C and holds exactly 8 cycles; hex4..7=1,2,3,4 with en=8'hF9 before C; hex0=2 during OPEN.
- Three mismatches: 0,0,0,0,C three times → first two give hex0=E for 4 cycles with hex3=1 then 2; third gives alarm high for 16 cycles and hex0=F. Keys during lockout are ignored. Afterwards hex3=0.
- Editing: 5,6,B,7,A,9,C → count=1 at C, C ignored. Then 9,8,7,C → ERROR with fail_cnt=1.
- Set-code: correct code, D during OPEN, then 4,3,2,1,C → door_open low from D, IDLE afterwards. 4,3,2,1,C opens the door; 1,2,3,4,C errors.
- Overflow and reset: 1,2,3,4,5 → fifth digit ignored, hex7=4. Assert rst_n during OPEN → door_open=0 immediately, en=8'b00001001, and code reverts to 1234.
